// File: rtl/maria_pkg.sv
// Shared types and header field positions for the MARIA display-list fetch sequencer.
package maria_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_H0     = 4'd1,
    ST_H1     = 4'd2,
    ST_H2     = 4'd3,
    ST_H3     = 4'd4,
    ST_H4     = 4'd5,
    ST_DECODE = 4'd6,
    ST_GFX    = 4'd7,
    ST_FIN    = 4'd8
  } dl_state_t;

  localparam logic [7:0] DL_END_BYTE = 8'h00;

  localparam int HDR_WM_BIT  = 7;
  localparam int HDR_IND_BIT = 5;
  localparam int PAL_MSB     = 7;
  localparam int PAL_LSB     = 5;
  localparam int WIDTH_MSB   = 4;

  // Width field counts up to 32; a field of zero is the full 32-byte object.
  function automatic logic [5:0] gfx_count(input logic [4:0] width);
    return 6'd32 - {1'b0, width};
  endfunction

endpackage

// File: rtl/maria_dl_fetch.sv
// Walks one scanline's display list, parses 4/5-byte headers and streams
// each object's graphics bytes to the line RAM write port.
module maria_dl_fetch
  import maria_pkg::*;
#(
  parameter int MAX_ENTRIES = 64
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ce,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] dl_addr,
  input  logic [3:0]  line_offset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  hpos,
  output logic [2:0]  palette,
  output logic        wm,
  output logic [7:0]  pixels,
  output logic        latch_byte,
  output logic        clear_hpos,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int ENTRY_W = $clog2(MAX_ENTRIES + 1);
  localparam logic [ENTRY_W-1:0] ENTRY_MAX = ENTRY_W'(MAX_ENTRIES);

  dl_state_t          state_r, state_n;
  logic [15:0]        ptr_r, ptr_n;
  logic [7:0]         lo_r, lo_n;
  logic [7:0]         hi_r, hi_n;
  logic [7:0]         hdr_hpos_r, hdr_hpos_n;
  logic [2:0]         pal_r, pal_n;
  logic [4:0]         width_r, width_n;
  logic               ind_r, ind_n;
  logic               ext_r, ext_n;
  logic               wm_r, wm_n;
  logic [3:0]         off_r, off_n;
  logic [15:0]        gaddr_r, gaddr_n;
  logic [5:0]         cnt_r, cnt_n;
  logic [ENTRY_W-1:0] entry_r, entry_n;
  logic               req_r, req_n;
  logic [15:0]        addr_r, addr_n;
  logic [7:0]         hpos_r, hpos_n;
  logic [2:0]         palette_r, palette_n;
  logic [7:0]         pixels_r, pixels_n;
  logic               overflow_r, overflow_n;

  logic               ack_s;
  logic [15:0]        ptr_inc_s;
  logic [15:0]        gaddr_inc_s;
  logic [ENTRY_W-1:0] entry_inc_s;
  logic [15:0]        obj_addr_s;

  assign ack_s       = ce & req_r & mem_ack;
  assign ptr_inc_s   = ptr_r + 16'd1;
  assign gaddr_inc_s = gaddr_r + 16'd1;
  assign entry_inc_s = entry_r + ENTRY_W'(1);
  assign obj_addr_s  = {hi_r + {4'b0000, off_r}, lo_r};

  // Strobes are combinational so they coincide with the ce that causes them.
  assign latch_byte = ce & ~abort & (state_r == ST_GFX) & req_r & mem_ack;
  assign clear_hpos = ce & ~abort & (state_r == ST_DECODE) & ~ind_r;
  assign done       = ce & ~abort & (state_r == ST_FIN);

  assign pixels   = latch_byte ? mem_data : pixels_r;
  assign mem_req  = req_r;
  assign mem_addr = addr_r;
  assign hpos     = hpos_r;
  assign palette  = palette_r;
  assign wm       = wm_r;
  assign busy     = (state_r != ST_IDLE);
  assign overflow = overflow_r;

  // Next-state, header capture and request generation.
  always_comb begin
    state_n    = state_r;
    ptr_n      = ptr_r;
    lo_n       = lo_r;
    hi_n       = hi_r;
    hdr_hpos_n = hdr_hpos_r;
    pal_n      = pal_r;
    width_n    = width_r;
    ind_n      = ind_r;
    ext_n      = ext_r;
    wm_n       = wm_r;
    off_n      = off_r;
    gaddr_n    = gaddr_r;
    cnt_n      = cnt_r;
    entry_n    = entry_r;
    req_n      = req_r;
    addr_n     = addr_r;
    hpos_n     = hpos_r;
    palette_n  = palette_r;
    pixels_n   = pixels_r;
    overflow_n = overflow_r;

    if (!ce) begin
      state_n = state_r;
    end else if (abort) begin
      state_n = ST_IDLE;
      req_n   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            ptr_n      = dl_addr;
            off_n      = line_offset;
            entry_n    = '0;
            overflow_n = 1'b0;
            state_n    = ST_H0;
            req_n      = 1'b1;
            addr_n     = dl_addr;
          end else begin
            req_n = 1'b0;
          end
        end
        ST_H0: begin
          if (ack_s) begin
            lo_n    = mem_data;
            ptr_n   = ptr_inc_s;
            addr_n  = ptr_inc_s;
            state_n = ST_H1;
          end else begin
            req_n = 1'b1;
          end
        end
        ST_H1: begin
          if (ack_s) begin
            ptr_n  = ptr_inc_s;
            addr_n = ptr_inc_s;
            if (mem_data == DL_END_BYTE) begin
              req_n   = 1'b0;
              state_n = ST_FIN;
            end else if (mem_data[WIDTH_MSB:0] != 5'd0) begin
              pal_n   = mem_data[PAL_MSB:PAL_LSB];
              width_n = mem_data[WIDTH_MSB:0];
              ind_n   = 1'b0;
              ext_n   = 1'b0;
              state_n = ST_H2;
            end else begin
              wm_n    = mem_data[HDR_WM_BIT];
              ind_n   = mem_data[HDR_IND_BIT];
              ext_n   = 1'b1;
              state_n = ST_H2;
            end
          end else begin
            req_n = 1'b1;
          end
        end
        ST_H2: begin
          if (ack_s) begin
            hi_n    = mem_data;
            ptr_n   = ptr_inc_s;
            addr_n  = ptr_inc_s;
            state_n = ST_H3;
          end else begin
            req_n = 1'b1;
          end
        end
        ST_H3: begin
          if (ack_s) begin
            ptr_n  = ptr_inc_s;
            addr_n = ptr_inc_s;
            if (ext_r) begin
              pal_n   = mem_data[PAL_MSB:PAL_LSB];
              width_n = mem_data[WIDTH_MSB:0];
              state_n = ST_H4;
            end else begin
              hdr_hpos_n = mem_data;
              req_n      = 1'b0;
              state_n    = ST_DECODE;
            end
          end else begin
            req_n = 1'b1;
          end
        end
        ST_H4: begin
          if (ack_s) begin
            hdr_hpos_n = mem_data;
            ptr_n      = ptr_inc_s;
            req_n      = 1'b0;
            state_n    = ST_DECODE;
          end else begin
            req_n = 1'b1;
          end
        end
        ST_DECODE: begin
          entry_n = entry_inc_s;
          if (ind_r) begin
            if (entry_inc_s == ENTRY_MAX) begin
              overflow_n = 1'b1;
              req_n      = 1'b0;
              state_n    = ST_FIN;
            end else begin
              req_n   = 1'b1;
              addr_n  = ptr_r;
              state_n = ST_H0;
            end
          end else begin
            hpos_n    = hdr_hpos_r;
            palette_n = pal_r;
            gaddr_n   = obj_addr_s;
            cnt_n     = gfx_count(width_r);
            req_n     = 1'b1;
            addr_n    = obj_addr_s;
            state_n   = ST_GFX;
          end
        end
        ST_GFX: begin
          if (ack_s) begin
            pixels_n = mem_data;
            gaddr_n  = gaddr_inc_s;
            cnt_n    = cnt_r - 6'd1;
            if (cnt_r != 6'd1) begin
              addr_n = gaddr_inc_s;
            end else if (entry_r == ENTRY_MAX) begin
              overflow_n = 1'b1;
              req_n      = 1'b0;
              state_n    = ST_FIN;
            end else begin
              addr_n  = ptr_r;
              state_n = ST_H0;
            end
          end else begin
            req_n = 1'b1;
          end
        end
        ST_FIN: begin
          req_n   = 1'b0;
          state_n = ST_IDLE;
        end
        default: begin
          req_n   = 1'b0;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 16'h0000;
      lo_r       <= 8'h00;
      hi_r       <= 8'h00;
      hdr_hpos_r <= 8'h00;
      pal_r      <= 3'd0;
      width_r    <= 5'd0;
      ind_r      <= 1'b0;
      ext_r      <= 1'b0;
      wm_r       <= 1'b0;
      off_r      <= 4'd0;
      gaddr_r    <= 16'h0000;
      cnt_r      <= 6'd0;
      entry_r    <= '0;
      req_r      <= 1'b0;
      addr_r     <= 16'h0000;
      hpos_r     <= 8'h00;
      palette_r  <= 3'd0;
      pixels_r   <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      ptr_r      <= ptr_n;
      lo_r       <= lo_n;
      hi_r       <= hi_n;
      hdr_hpos_r <= hdr_hpos_n;
      pal_r      <= pal_n;
      width_r    <= width_n;
      ind_r      <= ind_n;
      ext_r      <= ext_n;
      wm_r       <= wm_n;
      off_r      <= off_n;
      gaddr_r    <= gaddr_n;
      cnt_r      <= cnt_n;
      entry_r    <= entry_n;
      req_r      <= req_n;
      addr_r     <= addr_n;
      hpos_r     <= hpos_n;
      palette_r  <= palette_n;
      pixels_r   <= pixels_n;
      overflow_r <= overflow_n;
    end
  end

endmodule

// File: tb/tb_maria_dl_fetch.sv
// Directed bench for maria_dl_fetch: behavioural memory with optional random
// wait states, and a scoreboard of expected line_ram writes.
module tb_maria_dl_fetch;

  logic        clk_sys = 1'b0;
  logic        RESET, ce, start, abort, mem_ack;
  logic [15:0] dl_addr;
  logic [3:0]  line_offset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, hpos, pixels;
  logic [2:0]  palette;
  logic        wm, latch_byte, clear_hpos, busy, done, overflow;

  always #5 clk_sys = ~clk_sys;

  maria_dl_fetch #(.MAX_ENTRIES(64)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ce(ce), .start(start), .abort(abort),
    .dl_addr(dl_addr), .line_offset(line_offset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .hpos(hpos), .palette(palette), .wm(wm), .pixels(pixels),
    .latch_byte(latch_byte), .clear_hpos(clear_hpos), .busy(busy), .done(done),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] hpos;
    logic [2:0] pal;
    logic       wm;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_log[$];
  logic [7:0]  mem[0:65535];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt, clr_cnt, req_cnt, wait_cnt;
  bit          rand_mode, do_start, outstanding, abort_arm;
  logic [15:0] pend_addr, abort_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs and serve memory after the edge, observe outputs at the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk_sys);
    #1;
    if (do_start) begin
      start = 1'b1; ce = 1'b1; do_start = 1'b0;
    end else begin
      start = 1'b0;
      ce = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    abort = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
    if (mem_req !== 1'b1) begin
      outstanding = 1'b0;
    end else begin
      req_cnt++;
      if (outstanding) chk("addr_stable", {16'd0, mem_addr}, {16'd0, pend_addr});
      else begin
        outstanding = 1'b1; pend_addr = mem_addr;
        wait_cnt = rand_mode ? int'($urandom_range(0, 7)) : 0;
      end
      if (ce) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1; mem_data = mem[mem_addr]; rd_log.push_back(mem_addr);
          outstanding = 1'b0;
          if (abort_arm && mem_addr == abort_addr) begin abort = 1'b1; abort_arm = 1'b0; end
        end else wait_cnt--;
      end
    end
    @(negedge clk_sys);
    if (!ce) chk("strobe_gate", {29'd0, latch_byte, clear_hpos, done}, 32'd0);
    if (latch_byte === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_latch", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("latch", {12'd0, pixels, hpos, palette, wm}, {12'd0, e});
      end
    end
    if (done === 1'b1) done_cnt++;
    if (clear_hpos === 1'b1) clr_cnt++;
  endtask

  task automatic push_gfx(input logic [15:0] ga, input int n, input logic [7:0] hp,
                          input logic [2:0] pal, input logic w);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = ga + 16'(i);
      exp_q.push_back({mem[a], hp, pal, w});
    end
  endtask

  task automatic run_line(input logic [15:0] base, input logic [3:0] off, input int budget);
    int n;
    dl_addr = base; line_offset = off;
    done_cnt = 0; clr_cnt = 0; rd_log.delete(); do_start = 1'b1;
    tick();
    n = 0;
    do begin tick(); n++; end while (busy === 1'b1 && n < budget);
    chk("line_timeout", {31'd0, busy}, 32'd0);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [15:0] t1_rd[7];

  initial begin
    t1_rd = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'hA200, 16'h0104, 16'h0105};
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7) + (i >> 8) * 13 + 5);
    // T1 list at 0100, extended lists at 1000/2000, runaway list at 4000
    mem[16'h0100] = 8'h00; mem[16'h0101] = 8'h3F; mem[16'h0102] = 8'hA0;
    mem[16'h0103] = 8'h10; mem[16'h0104] = 8'h00; mem[16'h0105] = 8'h00;
    mem[16'h2000] = 8'h00; mem[16'h2001] = 8'h80; mem[16'h2002] = 8'hC0;
    mem[16'h2003] = 8'h5C; mem[16'h2004] = 8'h20; mem[16'h2005] = 8'h00; mem[16'h2006] = 8'h00;
    mem[16'h1000] = 8'hF0; mem[16'h1001] = 8'h40; mem[16'h1002] = 8'hFF;
    mem[16'h1003] = 8'h60; mem[16'h1004] = 8'h30; mem[16'h1005] = 8'h00; mem[16'h1006] = 8'h00;
    for (int k = 0; k < 64; k++) begin
      mem[16'h4000 + 16'(4 * k)]     = 8'(k);
      mem[16'h4000 + 16'(4 * k + 1)] = 8'h3F;
      mem[16'h4000 + 16'(4 * k + 2)] = 8'h30;
      mem[16'h4000 + 16'(4 * k + 3)] = 8'(k);
    end

    RESET = 1'b1; ce = 1'b1; start = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
    dl_addr = 16'h0000; line_offset = 4'd0;
    rand_mode = 1'b0; do_start = 1'b0; outstanding = 1'b0; abort_arm = 1'b0;
    pend_addr = 16'h0000; abort_addr = 16'h0000; wait_cnt = 0;
    done_cnt = 0; clr_cnt = 0; req_cnt = 0;
    repeat (2) @(negedge clk_sys);
    chk("rst_mem", {15'd0, mem_req, mem_addr}, 32'd0);
    chk("rst_obj", {12'd0, hpos, palette, wm, pixels}, 32'd0);
    chk("rst_flags", {27'd0, latch_byte, clear_hpos, busy, done, overflow}, 32'd0);
    RESET = 1'b0;

    // reset in the middle of a header fetch
    dl_addr = 16'h0100; line_offset = 4'd2; do_start = 1'b1;
    repeat (3) tick();
    #2 RESET = 1'b1;
    #1 chk("midreset", {30'd0, mem_req, busy}, 32'd0);
    @(negedge clk_sys); RESET = 1'b0;

    // T1: 4-byte header, one graphics byte at A200
    push_gfx(16'hA200, 1, 8'h10, 3'd1, 1'b0);
    run_line(16'h0100, 4'd2, 200);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_clr", 32'(clr_cnt), 32'd1);
    chk("t1_nreads", 32'(rd_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < rd_log.size(); i++) chk("t1_read", {16'd0, rd_log[i]}, {16'd0, t1_rd[i]});

    // T2: 5-byte header, wm=1, four bytes at C000
    push_gfx(16'hC000, 4, 8'h20, 3'd2, 1'b1);
    run_line(16'h2000, 4'd0, 200);
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_nreads", 32'(rd_log.size()), 32'd11);

    // T3: width 0 -> 32 bytes wrapping from FFF0 through 000F
    push_gfx(16'hFFF0, 32, 8'h30, 3'd3, 1'b0);
    run_line(16'h1000, 4'd0, 400);
    chk("t3_done", 32'(done_cnt), 32'd1);
    chk("t3_clr", 32'(clr_cnt), 32'd1);
    chk("t3_nreads", 32'(rd_log.size()), 32'd39);

    // T4: runaway list hits the entry limit
    for (int k = 0; k < 64; k++) push_gfx({8'h30, 8'(k)}, 1, 8'(k), 3'd1, 1'b0);
    run_line(16'h4000, 4'd0, 3000);
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    chk("t4_done", 32'(done_cnt), 32'd1);
    chk("t4_clr", 32'(clr_cnt), 32'd64);
    chk("t4_nreads", 32'(rd_log.size()), 32'd320);
    req_cnt = 0;
    repeat (8) tick();
    chk("t4_noreq", 32'(req_cnt), 32'd0);

    // T5: abort on the ack of the third graphics byte
    push_gfx(16'hC000, 2, 8'h20, 3'd2, 1'b1);
    abort_addr = 16'hC002; abort_arm = 1'b1;
    dl_addr = 16'h2000; line_offset = 4'd0; done_cnt = 0; do_start = 1'b1;
    for (int n = 0; n < 100 && abort_arm; n++) tick();
    chk("t5_abort_hit", {31'd0, abort_arm}, 32'd0);
    tick();
    chk("t5_idle", {30'd0, busy, mem_req}, 32'd0);
    chk("t5_nodone", 32'(done_cnt), 32'd0);
    chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // T1 again after the abort; wm still holds the value from the aborted header
    push_gfx(16'hA200, 1, 8'h10, 3'd1, 1'b1);
    run_line(16'h0100, 4'd2, 200);
    chk("t6_done", 32'(done_cnt), 32'd1);

    // random wait states and ce gaps
    rand_mode = 1'b1;
    push_gfx(16'hFFF0, 32, 8'h30, 3'd3, 1'b0);
    run_line(16'h1000, 4'd0, 3000);
    chk("r3_done", 32'(done_cnt), 32'd1);
    push_gfx(16'hC000, 4, 8'h20, 3'd2, 1'b1);
    run_line(16'h2000, 4'd0, 2000);
    chk("r2_done", 32'(done_cnt), 32'd1);
    chk("r2_nreads", 32'(rd_log.size()), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
